// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download sequencer.
package rom_load_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [7:0] IDX_ROM     = 8'd0;
    localparam logic [7:0] IDX_SYSMODE = 8'd1;
    localparam logic [7:0] IDX_DSW     = 8'd254;

    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = ADDR_W + DATA_W;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible on dout while not empty.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rom_load_seq.sv
// Routes HPS download strobes to a buffered ROM write port, mode/DIP registers,
// and sequences the game core reset around ROM loads.
module rom_load_seq
    import rom_load_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 256
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        rom_wr,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    input  logic        rom_ready,
    output logic [7:0]  sysmode,
    output logic [63:0] dsw,
    output logic        core_rst,
    output logic        overrun
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LVL_W-1:0] WAIT_LVL  = LVL_W'(FIFO_DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    hold_cnt;
    logic [CNT_W-1:0]    hold_cnt_nxt;
    logic                rom_req;
    logic                rom_start;
    logic                drain_done;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_head;

    // Handshake: an entry moves to the core on every edge where it is queued and
    // rom_ready=1; rom_wr marks the following cycle. ioctl_wait asks the HPS to stop
    // one entry early so a strobe already in flight still fits.
    assign rom_req    = ioctl_wr && (ioctl_index == IDX_ROM);
    assign rom_start  = ioctl_download && (ioctl_index == IDX_ROM);
    assign fifo_pop   = !fifo_empty && rom_ready;
    assign drain_done = fifo_empty ||
                        ((fifo_count == LVL_W'(1)) && fifo_pop && !rom_req);
    assign ioctl_wait = (fifo_count >= WAIT_LVL);
    assign core_rst   = (state != ST_RUN);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push    (rom_req),
        .pop     (fifo_pop),
        .din     ({ioctl_addr, ioctl_dout}),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            ST_RUN: begin
                if (rom_start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    if (drain_done) begin
                        state_nxt    = ST_HOLD;
                        hold_cnt_nxt = HOLD_LOAD;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rom_start) begin
                    state_nxt = ST_LOAD;
                end else if (drain_done) begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (rom_start) begin
                    state_nxt = ST_LOAD;
                end else if (hold_cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = ST_HOLD;
                hold_cnt_nxt = HOLD_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
            overrun  <= 1'b0;
            rom_wr   <= 1'b0;
            rom_addr <= '0;
            rom_data <= '0;
            sysmode  <= '0;
            dsw      <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            rom_wr   <= fifo_pop;
            if (fifo_pop) {rom_addr, rom_data} <= fifo_head;
            // A dropped write outranks the clear when both land on one edge.
            if (rom_req && fifo_full && !fifo_pop)
                overrun <= 1'b1;
            else if (state != ST_LOAD && state_nxt == ST_LOAD)
                overrun <= 1'b0;
            if (ioctl_wr && ioctl_index == IDX_SYSMODE && ioctl_addr == '0)
                sysmode <= ioctl_dout;
            if (ioctl_wr && ioctl_index == IDX_DSW && ioctl_addr[24:3] == '0)
                dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

endmodule

// File: tb/tb_rom_load_seq.sv
// Directed bench for rom_load_seq: routing table plus load/drain/hold/reset sequences.
module tb_rom_load_seq;

    logic        clk_sys;
    logic        rst_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        rom_wr;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ready;
    logic [7:0]  sysmode;
    logic [63:0] dsw;
    logic        core_rst;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_sysmode;
        logic [63:0] exp_dsw;
    } vec_t;
    vec_t vecs[8];

    rom_load_seq #(.FIFO_DEPTH(4), .HOLD_CYCLES(256)) dut (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_wr         (rom_wr),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_ready      (rom_ready),
        .sysmode        (sysmode),
        .dsw            (dsw),
        .core_rst       (core_rst),
        .overrun        (overrun)
    );

    // clock / watchdog
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // scoreboard: every rom_wr pulse must match the oldest expected entry
    always @(negedge clk_sys) begin
        if (rst_n && rom_wr) begin
            total++;
            pulses++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rom_wr_unexpected: got addr=%0h data=%0h, required no write",
                         rom_addr, rom_data);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({rom_addr, rom_data} !== e) begin
                    bad++;
                    $display("FAIL rom_wr_data: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             rom_addr, rom_data, e[32:8], e[7:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        step();
        ioctl_wr    = 1'b0;
    endtask

    task automatic wr_rom(input logic [24:0] a, input logic [7:0] d, input bit expect_out);
        if (expect_out) exp_q.push_back({a, d});
        wr_byte(8'd0, a, d);
    endtask

    // cycles until core_rst falls, restarting the count on each rom_wr pulse
    task automatic count_hold(output int n);
        n = 0;
        for (int i = 0; i < 600 && core_rst; i++) begin
            step();
            n++;
            if (rom_wr) n = 0;
        end
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 64) begin
            step();
            guard++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;

        vecs[0] = '{8'd1,   25'd0, 8'h05, 8'h05, 64'h0};
        vecs[1] = '{8'd1,   25'd1, 8'hFF, 8'h05, 64'h0};
        vecs[2] = '{8'd254, 25'd3, 8'h12, 8'h05, 64'h0000_0000_1200_0000};
        vecs[3] = '{8'd254, 25'd8, 8'hFF, 8'h05, 64'h0000_0000_1200_0000};
        vecs[4] = '{8'd254, 25'd7, 8'h9A, 8'h05, 64'h9A00_0000_1200_0000};
        vecs[5] = '{8'd2,   25'd0, 8'h77, 8'h05, 64'h9A00_0000_1200_0000};
        vecs[6] = '{8'd254, 25'd0, 8'h3C, 8'h05, 64'h9A00_0000_1200_003C};
        vecs[7] = '{8'd1,   25'd0, 8'h06, 8'h06, 64'h9A00_0000_1200_003C};

        rst_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_index = 8'd0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        rom_ready = 1'b1;
        repeat (3) step();

        // reset values
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_rom_wr", 64'(rom_wr), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_rom_data", 64'(rom_data), 64'd0);
        chk("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_sysmode", 64'(sysmode), 64'd0);
        chk("rst_dsw", dsw, 64'd0);

        // reset release with no download: 256 held cycles
        rst_n = 1'b1;
        count_hold(n);
        chk("boot_hold_len", 64'(n), 64'd256);
        chk("boot_run", 64'(core_rst), 64'd0);

        // 16-byte ROM download with latency check
        ioctl_download = 1'b1;
        ioctl_index = 8'd0;
        step();
        chk("load_core_rst", 64'(core_rst), 64'd1);
        for (int i = 0; i < 16; i++) begin
            wr_rom(25'(i), 8'(i) ^ 8'hA5, 1'b1);
            if (i == 0) chk("lat_edge_k", 64'(rom_wr), 64'd0);
            if (i == 1) chk("lat_edge_k1", 64'(rom_wr), 64'd1);
        end
        ioctl_download = 1'b0;
        count_hold(n);
        chk("burst_hold_len", 64'(n), 64'd256);
        chk("burst_drained", 64'(exp_q.size()), 64'd0);
        chk("burst_run", 64'(core_rst), 64'd0);

        // back-pressure and overrun with rom_ready low
        rom_ready = 1'b0;
        ioctl_download = 1'b1;
        ioctl_index = 8'd0;
        step();
        wr_rom(25'h20, 8'h30, 1'b1);
        wr_rom(25'h21, 8'h31, 1'b1);
        chk("wait_after_2", 64'(ioctl_wait), 64'd0);
        wr_rom(25'h22, 8'h32, 1'b1);
        chk("wait_after_3", 64'(ioctl_wait), 64'd1);
        wr_rom(25'h23, 8'h33, 1'b1);
        chk("overrun_after_4", 64'(overrun), 64'd0);
        wr_rom(25'h24, 8'h34, 1'b0);
        chk("overrun_after_5", 64'(overrun), 64'd1);
        pulses = 0;
        rom_ready = 1'b1;
        wait_drain("bp_drain");
        repeat (3) step();
        chk("bp_pulses", 64'(pulses), 64'd4);
        chk("bp_wait_low", 64'(ioctl_wait), 64'd0);
        chk("bp_overrun_sticky", 64'(overrun), 64'd1);

        // restart download at hold count 100
        ioctl_download = 1'b0;
        repeat (156) step();
        chk("hold100_core_rst", 64'(core_rst), 64'd1);
        chk("hold100_overrun", 64'(overrun), 64'd1);
        ioctl_download = 1'b1;
        ioctl_index = 8'd0;
        step();
        chk("reload_overrun_clr", 64'(overrun), 64'd0);
        wr_rom(25'h100, 8'hAA, 1'b1);
        wr_rom(25'h101, 8'h55, 1'b1);
        wait_drain("reload_drain");
        step();
        ioctl_download = 1'b0;
        count_hold(n);
        chk("reload_hold_len", 64'(n), 64'd257);
        chk("reload_run", 64'(core_rst), 64'd0);

        // routing table during RUN
        for (int i = 0; i < 8; i++) begin
            ioctl_download = 1'b1;
            wr_byte(vecs[i].idx, vecs[i].addr, vecs[i].data);
            chk($sformatf("route%0d_sysmode", i), 64'(sysmode), 64'(vecs[i].exp_sysmode));
            chk($sformatf("route%0d_dsw", i), dsw, vecs[i].exp_dsw);
            chk($sformatf("route%0d_core_rst", i), 64'(core_rst), 64'd0);
        end
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        step();

        // reset with two pending entries: they must never reach the core
        rom_ready = 1'b0;
        ioctl_download = 1'b1;
        step();
        wr_rom(25'h40, 8'hC1, 1'b0);
        wr_rom(25'h41, 8'hC2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("mid_rst_core_rst", 64'(core_rst), 64'd1);
        chk("mid_rst_wait", 64'(ioctl_wait), 64'd0);
        chk("mid_rst_sysmode", 64'(sysmode), 64'd0);
        ioctl_download = 1'b0;
        rom_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        pulses = 0;
        count_hold(n);
        chk("post_rst_hold_len", 64'(n), 64'd256);
        chk("post_rst_pulses", 64'(pulses), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_load_seq.md
ROM_LOAD_SEQ -- requirements
Module: rom_load_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: ROM write buffer depth in entries, power of two, minimum 2.
REQ-002 Parameter HOLD_CYCLES, default 256: number of clk_sys cycles core reset is held after a load drains, minimum 1.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 clk_sys  in  1  system clock (48 MHz domain); all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ioctl_download  in  1  HPS download in progress.
REQ-007 ioctl_wr  in  1  one-cycle write strobe from HPS.
REQ-008 ioctl_index  in  8  download target: 0 = game ROM, 1 = SYSMODE, 254 = DIP switches.
REQ-009 ioctl_addr  in  25  byte address within the download.
REQ-010 ioctl_dout  in  8  write data.
REQ-011 ioctl_wait  out  1  back-pressure to HPS.
REQ-012 rom_wr  out  1  one-cycle ROM write strobe to the game core.
REQ-013 rom_addr  out  25  ROM write address.
REQ-014 rom_data  out  8  ROM write data.
REQ-015 rom_ready  in  1  core can accept a ROM write this cycle.
REQ-016 sysmode  out  8  mode byte: [0] SYS1/SYS2, [1] H/V, [2] H256/H240.
REQ-017 dsw  out  64  DIP bytes; byte n occupies bits [8n+7:8n].
REQ-018 core_rst  out  1  active-high reset to the game core.
REQ-019 overrun  out  1  sticky flag: a ROM write was dropped.

Function
REQ-020 Write routing: ioctl_wr with index 0 SHALL push {addr,dout} into the FIFO.
REQ-021 Write routing: index 1 with addr 0 SHALL load sysmode.
REQ-022 Write routing: index 254 with addr[24:3] equal to 0 SHALL load dsw byte addr[2:0].
REQ-023 Write routing: every other index/address combination SHALL be ignored.
REQ-024 Drain: when the FIFO is non-empty and rom_ready=1 at an edge, the block SHALL pop the head entry.
REQ-025 Drain outputs: rom_wr, rom_addr and rom_data SHALL be registered; after a pop, rom_wr=1 for exactly the next cycle, otherwise rom_wr=0.
REQ-026 Drain latency: with the FIFO empty and rom_ready held at 1, ioctl_wr sampled at edge k SHALL give rom_wr=1 in the cycle following edge k+1.
REQ-027 Simultaneous push and pop in the same cycle SHALL leave the FIFO count unchanged and lose no data.
REQ-028 ioctl_wait SHALL be 1 while FIFO count is at least FIFO_DEPTH-1, giving one entry of slack for a strobe already in flight.
REQ-029 A push when the FIFO is full and no pop occurs that cycle SHALL be dropped and SHALL set overrun.
REQ-030 overrun SHALL clear only on reset or on entry to LOAD.
REQ-031 State machine: the states SHALL be LOAD, DRAIN, HOLD and RUN.
REQ-032 core_rst SHALL be 1 in every state except RUN.
REQ-033 Transition RUN -> LOAD: ioctl_download=1 with ioctl_index=0.
REQ-034 Downloads with index 1 or 254 SHALL NOT leave RUN.
REQ-035 Transition LOAD -> DRAIN when ioctl_download falls and the FIFO is non-empty; LOAD -> HOLD when it falls with the FIFO empty.
REQ-036 Transition DRAIN -> HOLD when the FIFO becomes empty.
REQ-037 In HOLD the counter SHALL load HOLD_CYCLES-1 on entry and decrement each cycle; at 0 the state SHALL move to RUN.
REQ-038 core_rst SHALL be high for exactly HOLD_CYCLES cycles of HOLD.
REQ-039 ioctl_download=1 with index 0 in DRAIN or HOLD SHALL return the state to LOAD, with the counter reloaded on the next HOLD entry.
REQ-040 The hold counter width SHALL be $clog2(HOLD_CYCLES+1); it SHALL NOT wrap.

Reset
REQ-041 Asserting rst_n low SHALL asynchronously empty the FIFO and set state=HOLD with counter=HOLD_CYCLES-1.
REQ-042 Values during reset: core_rst=1, rom_wr=0, rom_addr=0, rom_data=0, ioctl_wait=0, overrun=0, sysmode=0, dsw=0.
REQ-043 Reset asserted mid-load SHALL discard buffered entries; after release the block SHALL count HOLD, then enter RUN, unless a download is still active, in which case it SHALL enter LOAD.

Structure
REQ-044 A shared package rom_load_pkg SHALL hold the state enum and the constants IDX_ROM=0, IDX_SYSMODE=1 and IDX_DSW=254.
REQ-045 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width (33) and depth, with push, pop, full, empty and count ports.

Verification
REQ-046 Reset release, no download -> core_rst high for 256 cycles, then 0; rom_wr never asserted.
REQ-047 Index 0 download of 16 bytes at addr 0..15, data=addr^8'hA5, rom_ready=1 -> 16 rom_wr pulses in order with matching addr and data; core_rst falls 256 cycles after the last pulse.
REQ-048 rom_ready=0 during a burst of 4 strobes -> ioctl_wait rises after the 3rd push; the 4th is stored; a 5th strobe sets overrun; after rom_ready=1 exactly 4 writes occur.
REQ-049 Index 254 writes 8'h12 to addr 3 and 8'hFF to addr 8 during RUN -> dsw[31:24]=8'h12; rest unchanged; core_rst stays 0.
REQ-050 New index 0 download starting at HOLD count 100 -> state returns to LOAD, overrun cleared; after it ends, a full 256-cycle hold precedes RUN.
REQ-051 rst_n pulsed low with 2 FIFO entries pending -> no rom_wr is issued for the discarded entries; state restarts at HOLD.
